axi4lite_ram_slave: RTL and testbench



---
 rtl/axi4lite_ram_slave.sv | 187 ++++++++++++++++++
 tb/tb_axi4lite_ram_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_ram_slave.sv
// axi4lite_ram_slave
//   Word-organised on-chip RAM behind an AXI4-Lite slave port. The read and
//   write channels are independent FSMs that share one memory array. When a
//   write commit and an array read fall in the same cycle, the write goes
//   first and the read waits one cycle, so it returns the new data.
//
// Optional feature macro: AXI_RAM_WAIT_EN
//   When defined, every ready pulse is delayed by WAIT_CYCLES cycles using a
//   per-channel countdown. The countdown reloads whenever the valid input drops.
//
// Parameters
//   ADDR_BITS   word-address width (array holds 2**ADDR_BITS 32-bit words)
//   WAIT_CYCLES extra cycles before each ready pulse (AXI_RAM_WAIT_EN only)
//
// Ports
//   clk, rstn                        clock, synchronous active-low reset
//   ARdata/ARvalid/ARready/ARprot    read address channel (prot ignored)
//   Rdata/Rvalid/RReady              read data channel
//   AWdata/AWvalid/AWready/AWprot    write address channel (prot ignored)
//   Wdata/Wstrb/Wvalid/Wready        write data channel
//   Bvalid/Bready                    write response channel (always OKAY)
module axi4lite_ram_slave #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ARdata,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [2:0]  ARprot,
  output logic [31:0] Rdata,
  output logic        Rvalid,
  input  logic        RReady,
  input  logic [31:0] AWdata,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [2:0]  AWprot,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  input  logic        Wvalid,
  output logic        Wready,
  output logic        Bvalid,
  input  logic        Bready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

  r_state_t r_state, r_state_nx;
  w_state_t w_state, w_state_nx;

  logic [31:0]          mem [0:DEPTH-1];
  logic [ADDR_BITS-1:0] ar_idx, aw_idx;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic                 aw_got, w_got;
  logic                 ar_ready_nx, aw_ready_nx, w_ready_nx;
  logic                 ar_go, aw_go, w_go;
  logic                 ar_hs, aw_hs, w_hs;
  logic                 aw_have, w_have;
  logic                 rd_fire;

  assign ar_hs   = ARready & ARvalid;
  assign aw_hs   = AWready & AWvalid;
  assign w_hs    = Wready & Wvalid;
  // "have" includes a handshake happening on this edge, so the FSM can move
  // to commit in the cycle right after the last of the two handshakes.
  assign aw_have = aw_got | aw_hs;
  assign w_have  = w_got | w_hs;
  // The array read is held off while a commit owns the array this cycle.
  assign rd_fire = (r_state == R_READ) && (w_state != W_COMMIT);

  assign Rvalid = (r_state == R_RESP);
  assign Bvalid = (w_state == W_RESP);

  logic unused_bits;
  assign unused_bits = ^{ARprot, AWprot, ARdata[31:ADDR_BITS+2], ARdata[1:0],
                         AWdata[31:ADDR_BITS+2], AWdata[1:0]};

`ifdef AXI_RAM_WAIT_EN
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);

  logic [CW-1:0] ar_cnt, aw_cnt, w_cnt;

  // Count down only while a valid is pending in idle and no pulse is due;
  // any other situation (valid dropped, pulse issued) reloads the counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ar_cnt <= WAIT_LD;
      aw_cnt <= WAIT_LD;
      w_cnt  <= WAIT_LD;
    end else begin
      ar_cnt <= (r_state == R_IDLE && ARvalid && !ARready && !ar_go) ? ar_cnt - 1'b1 : WAIT_LD;
      aw_cnt <= (w_state == W_IDLE && AWvalid && !AWready && !aw_got && !aw_go) ? aw_cnt - 1'b1 : WAIT_LD;
      w_cnt  <= (w_state == W_IDLE && Wvalid && !Wready && !w_got && !w_go) ? w_cnt - 1'b1 : WAIT_LD;
    end
  end

  assign ar_go = (ar_cnt == '0);
  assign aw_go = (aw_cnt == '0);
  assign w_go  = (w_cnt == '0);
`else
  assign ar_go = 1'b1;
  assign aw_go = 1'b1;
  assign w_go  = 1'b1;
`endif

  // Read channel next-state
  always_comb begin
    r_state_nx  = r_state;
    ar_ready_nx = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) r_state_nx = R_READ;
        else if (ARvalid && !ARready && ar_go) ar_ready_nx = 1'b1;
      end
      R_READ:  if (rd_fire) r_state_nx = R_RESP;
      R_RESP:  if (RReady) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  // Write channel next-state
  always_comb begin
    w_state_nx  = w_state;
    aw_ready_nx = 1'b0;
    w_ready_nx  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_have && w_have) w_state_nx = W_COMMIT;
        if (!aw_have && AWvalid && !AWready && aw_go) aw_ready_nx = 1'b1;
        if (!w_have && Wvalid && !Wready && w_go) w_ready_nx = 1'b1;
      end
      W_COMMIT: w_state_nx = W_RESP;
      W_RESP:   if (Bready) w_state_nx = W_IDLE;
      default:  w_state_nx = W_IDLE;
    endcase
  end

  // Control state, ready pulses and read data register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      ARready <= 1'b0;
      AWready <= 1'b0;
      Wready  <= 1'b0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      Rdata   <= 32'h0;
    end else begin
      r_state <= r_state_nx;
      w_state <= w_state_nx;
      ARready <= ar_ready_nx;
      AWready <= aw_ready_nx;
      Wready  <= w_ready_nx;
      if (w_state == W_IDLE && w_state_nx == W_IDLE) begin
        aw_got <= aw_have;
        w_got  <= w_have;
      end else begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (rd_fire) Rdata <= mem[ar_idx];
    end
  end

  // Captured address/data and the array write port
  always_ff @(posedge clk) begin
    if (ar_hs && r_state == R_IDLE) ar_idx <= ARdata[ADDR_BITS+1:2];
    if (aw_hs) aw_idx <= AWdata[ADDR_BITS+1:2];
    if (w_hs) begin
      wdata_q <= Wdata;
      wstrb_q <= Wstrb;
    end
    if (rstn && w_state == W_COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[aw_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
module tb_axi4lite_ram_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] ARdata = '0;
  logic        ARvalid = 1'b0;
  logic        ARready;
  logic [2:0]  ARprot = 3'b000;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        RReady = 1'b0;
  logic [31:0] AWdata = '0;
  logic        AWvalid = 1'b0;
  logic        AWready;
  logic [2:0]  AWprot = 3'b000;
  logic [31:0] Wdata = '0;
  logic [3:0]  Wstrb = '0;
  logic        Wvalid = 1'b0;
  logic        Wready;
  logic        Bvalid;
  logic        Bready = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4lite_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn),
    .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
    .Rdata(Rdata), .Rvalid(Rvalid), .RReady(RReady),
    .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
    .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge. Cycle 0 is the cycle
  // in which the valids are raised; cycle n is sampled at the n-th next negedge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wdly,
                          output int aw_c, output int w_c, output int b_c);
    int c;
    c = 0; aw_c = -1; w_c = -1; b_c = -1;
    AWdata = addr; Wdata = data; Wstrb = strb;
    AWvalid = 1'b1; Wvalid = (wdly == 0); Bready = 1'b1;
    while (b_c < 0 && c < 30) begin
      @(negedge clk);
      c++;
      if (aw_c >= 0) AWvalid = 1'b0;
      if (w_c >= 0) Wvalid = 1'b0;
      if (c == wdly && w_c < 0) Wvalid = 1'b1;
      if (AWready && aw_c < 0) aw_c = c;
      if (Wready && w_c < 0) w_c = c;
      if (Bvalid) b_c = c;
    end
    AWvalid = 1'b0; Wvalid = 1'b0;
    @(negedge clk);
    Bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output int ar_c,
                         output int rv_c, output int stable_ok);
    int c;
    c = 0; ar_c = -1; rv_c = -1; stable_ok = 1; data = 'x;
    ARdata = addr; ARvalid = 1'b1; RReady = (hold == 0);
    while (rv_c < 0 && c < 30) begin
      @(negedge clk);
      c++;
      if (ar_c >= 0) ARvalid = 1'b0;
      if (ARready && ar_c < 0) ar_c = c;
      if (Rvalid) begin
        rv_c = c;
        data = Rdata;
      end
    end
    ARvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!Rvalid || Rdata !== data) stable_ok = 0;
    end
    RReady = 1'b1;
    @(negedge clk);
    RReady = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int aw_c, w_c, b_c, ar_c, rv_c, st;
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h0000_1010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h0000_1024, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0027, 32'h0,         4'b0000, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0003, 32'hA5A5_A5A5, 4'b1010, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'hA500_A500};
    vecs[13] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'b0000, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_ARready", {31'b0, ARready}, 32'h0);
    chk("rst_AWready", {31'b0, AWready}, 32'h0);
    chk("rst_Wready",  {31'b0, Wready},  32'h0);
    chk("rst_Rvalid",  {31'b0, Rvalid},  32'h0);
    chk("rst_Bvalid",  {31'b0, Bvalid},  32'h0);
    chk("rst_Rdata",   Rdata,            32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Word 1023 gets a known value before the table reads it via an aliased address.
    do_write(32'h0000_0FFC, 32'h1234_5678, 4'b1111, 0, aw_c, w_c, b_c);
    vecs[13].exp = 32'h1234_5678;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, aw_c, w_c, b_c);
        chk($sformatf("v%0d_awready_cyc", i), aw_c, 32'd1);
        chk($sformatf("v%0d_wready_cyc", i),  w_c,  32'd1);
        chk($sformatf("v%0d_bvalid_cyc", i),  b_c,  32'd3);
      end else begin
        do_read(vecs[i].addr, 0, rd, ar_c, rv_c, st);
        chk($sformatf("v%0d_arready_cyc", i), ar_c, 32'd1);
        chk($sformatf("v%0d_rvalid_cyc", i),  rv_c, 32'd3);
        chk($sformatf("v%0d_rdata", i),       rd,   vecs[i].exp);
      end
    end

    // Address three cycles ahead of data.
    do_write(32'h0000_0040, 32'h0BAD_CAFE, 4'b1111, 3, aw_c, w_c, b_c);
    chk("stagger_awready_cyc", aw_c, 32'd1);
    chk("stagger_wready_cyc",  w_c,  32'd4);
    chk("stagger_bvalid_cyc",  b_c,  32'd6);
    do_read(32'h0000_0040, 0, rd, ar_c, rv_c, st);
    chk("stagger_rdata", rd, 32'h0BAD_CAFE);

    // Master stalls the read response for four cycles.
    do_read(32'h0000_0010, 4, rd, ar_c, rv_c, st);
    chk("hold_rvalid_cyc", rv_c, 32'd3);
    chk("hold_rdata",      rd,   32'hDEAD_BEEF);
    chk("hold_stable",     st,   32'd1);
    chk("hold_rvalid_low", {31'b0, Rvalid}, 32'h0);

    // Read of word 5 collides with a commit to word 5.
    do_write(32'h0000_0014, 32'h0000_0000, 4'b1111, 0, aw_c, w_c, b_c);
    fork
      do_write(32'h0000_0014, 32'h0000_0055, 4'b1111, 0, aw_c, w_c, b_c);
      do_read(32'h0000_0014, 0, rd, ar_c, rv_c, st);
    join
    chk("conflict_bvalid_cyc", b_c,  32'd3);
    chk("conflict_rvalid_cyc", rv_c, 32'd4);
    chk("conflict_rdata",      rd,   32'h0000_0055);

    // Reset lands after the address handshake but before any write data.
    AWdata = 32'h0000_0010; AWvalid = 1'b1; Bready = 1'b1;
    @(negedge clk);
    chk("rstw_awready", {31'b0, AWready}, 32'h1);
    @(negedge clk);
    AWvalid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("rstw_ARready", {31'b0, ARready}, 32'h0);
    chk("rstw_AWready", {31'b0, AWready}, 32'h0);
    chk("rstw_Wready",  {31'b0, Wready},  32'h0);
    chk("rstw_Rvalid",  {31'b0, Rvalid},  32'h0);
    chk("rstw_Bvalid",  {31'b0, Bvalid},  32'h0);
    chk("rstw_Rdata",   Rdata,            32'h0);
    rstn = 1'b1;
    Bready = 1'b0;
    @(negedge clk);
    // A full write elsewhere must use its own address, not the discarded one.
    do_write(32'h0000_0030, 32'h7777_7777, 4'b1111, 0, aw_c, w_c, b_c);
    chk("rstw_next_bvalid_cyc", b_c, 32'd3);
    do_read(32'h0000_0010, 0, rd, ar_c, rv_c, st);
    chk("rstw_target_unchanged", rd, 32'hDEAD_BEEF);
    do_read(32'h0000_0030, 0, rd, ar_c, rv_c, st);
    chk("rstw_next_rdata", rd, 32'h7777_7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
